// File: rtl/pixel_fetch_pkg.sv
// Shared types and widths for the frame-memory pixel streamer.
// Pure declarations, no logic.
// Imported by the streamer and its word FIFO.
package pixel_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int PIX_W        = 16;
    localparam int WORD_W       = 32;
    localparam int PIX_PER_WORD = 2;

endpackage

// File: rtl/pixel_fetch_fifo.sv
// Word FIFO between the memory read port and the pixel unpacker.
// Head word is visible the cycle after its push edge; registered full/empty.
// Push is dropped when full and pop when empty; the streamer's credit check keeps both from happening.
module pixel_fetch_fifo
    import pixel_fetch_pkg::*;
#(
    parameter int WIDTH = WORD_W,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_dat,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;
    logic [AW:0]      count_next;

    assign do_push    = push && !full;
    assign do_pop     = pop && !empty;
    assign count_next = count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    assign pop_dat    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_next;
            full  <= (count_next == (AW+1)'(DEPTH));
            empty <= (count_next == '0);
        end
    end

endmodule

// File: rtl/pixel_fetch_streamer.sv
// Scans one frame of 32-bit words from frame memory into an RGB565 Avalon-ST packet (optional PIXEL_FETCH_TEST_PATTERN_EN ramp).
// Latency: start edge n -> first read from n, sop valid from n+2; 1 pixel/clk sustained.
// Backpressure: pix_ready low holds the pixel stable; reads stop once FIFO + in-flight words fill FIFO_DEPTH.
module pixel_fetch_streamer
    import pixel_fetch_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR   = 16'h0000,
    parameter int          FRAME_WORDS = 51200,
    parameter int          FIFO_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
`ifdef PIXEL_FETCH_TEST_PATTERN_EN
    input  logic        test_pattern,
`endif
    output logic        busy,
    output logic        done,
    output logic [15:0] mem_address,
    output logic        mem_chipselect,
    output logic        mem_write,
    output logic [3:0]  mem_byteenable,
    output logic        mem_clken,
    input  logic [31:0] mem_readdata,
    output logic [15:0] pix_data,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic        pix_sop,
    output logic        pix_eop
);

    localparam int          AW       = $clog2(FIFO_DEPTH);
    localparam logic [16:0] LAST_PIX = 17'(PIX_PER_WORD * FRAME_WORDS - 1);

    state_t              state;
    logic [15:0]         next_addr;
    logic [16:0]         words_left;
    logic [16:0]         pix_idx;
    logic                inflight_q;
    logic [AW:0]         fifo_count;
    logic                fifo_full;
    logic                fifo_empty;
    logic [WORD_W-1:0]   fifo_head;
    logic [WORD_W-1:0]   push_dat;
    logic                push;
    logic                pop;
    logic                hs;
    logic [AW+1:0]       occ;
    logic                can_issue;

    assign mem_write      = 1'b0;
    assign mem_byteenable = 4'hF;
    assign mem_clken      = 1'b1;

    assign pix_valid = !fifo_empty;
    assign hs        = pix_valid && pix_ready;
    assign pop       = hs && (pix_idx[0] == 1'(PIX_PER_WORD - 1));
    assign push      = inflight_q && !fifo_full;
    assign pix_data  = !pix_valid ? '0 :
                       pix_idx[0] ? fifo_head[WORD_W-1:PIX_W] : fifo_head[PIX_W-1:0];
    assign pix_sop   = pix_valid && (pix_idx == '0);
    assign pix_eop   = pix_valid && (pix_idx == LAST_PIX);

    // Entries committed after this edge: stored words, the read landing now, and the read on the bus.
    assign occ       = {1'b0, fifo_count} + (AW+2)'(push) + (AW+2)'(mem_chipselect) - (AW+2)'(pop);
    assign can_issue = occ < (AW+2)'(FIFO_DEPTH);

`ifdef PIXEL_FETCH_TEST_PATTERN_EN
    logic             tp_q;
    logic [PIX_W-1:0] tp_idx;

    always_ff @(posedge clk) begin
        if (reset) begin
            tp_q   <= 1'b0;
            tp_idx <= '0;
        end else if (state == IDLE && start) begin
            tp_q   <= test_pattern;
            tp_idx <= '0;
        end else if (push) begin
            tp_idx <= tp_idx + 16'd2;
        end
    end

    assign push_dat = tp_q ? {tp_idx + 16'd1, tp_idx} : mem_readdata;
`else
    assign push_dat = mem_readdata;
`endif

    pixel_fetch_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .push_dat (push_dat),
        .pop      (pop),
        .pop_dat  (fifo_head),
        .count    (fifo_count),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            busy           <= 1'b0;
            done           <= 1'b0;
            mem_chipselect <= 1'b0;
            mem_address    <= '0;
            next_addr      <= '0;
            words_left     <= '0;
            pix_idx        <= '0;
            inflight_q     <= 1'b0;
        end else begin
            done       <= 1'b0;
            inflight_q <= mem_chipselect;
            if (hs) pix_idx <= pix_idx + 17'd1;
            case (state)
                IDLE: begin
                    if (start) begin
                        busy           <= 1'b1;
                        mem_chipselect <= 1'b1;
                        mem_address    <= BASE_ADDR;
                        next_addr      <= BASE_ADDR + 16'd1;
                        words_left     <= 17'(FRAME_WORDS - 1);
                        pix_idx        <= '0;
                        state          <= (FRAME_WORDS == 1) ? DRAIN : FETCH;
                    end
                end
                FETCH: begin
                    if (can_issue) begin
                        mem_chipselect <= 1'b1;
                        mem_address    <= next_addr;
                        next_addr      <= next_addr + 16'd1;
                        words_left     <= words_left - 17'd1;
                        if (words_left == 17'd1) state <= DRAIN;
                    end else begin
                        mem_chipselect <= 1'b0;
                    end
                end
                DRAIN: begin
                    mem_chipselect <= 1'b0;
                    // The eop pop empties the FIFO; every read has already landed by then.
                    if (hs && pix_eop) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_fetch_streamer.sv
module tb_pixel_fetch_streamer;

    localparam logic [15:0] BASE  = 16'h0100;
    localparam int          FW    = 6;
    localparam int          DEPTH = 4;

    typedef struct packed {
        logic [15:0] d;
        logic        sop;
        logic        eop;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        pix_ready = 1'b0;
    logic        busy, done;
    logic [15:0] mem_address;
    logic        mem_chipselect, mem_write, mem_clken;
    logic [3:0]  mem_byteenable;
    logic [31:0] mem_readdata;
    logic [15:0] pix_data;
    logic        pix_valid, pix_sop, pix_eop;
`ifdef PIXEL_FETCH_TEST_PATTERN_EN
    logic        test_pattern = 1'b0;
`endif

    pixel_fetch_streamer #(
        .BASE_ADDR   (BASE),
        .FRAME_WORDS (FW),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
`ifdef PIXEL_FETCH_TEST_PATTERN_EN
        .test_pattern   (test_pattern),
`endif
        .busy           (busy),
        .done           (done),
        .mem_address    (mem_address),
        .mem_chipselect (mem_chipselect),
        .mem_write      (mem_write),
        .mem_byteenable (mem_byteenable),
        .mem_clken      (mem_clken),
        .mem_readdata   (mem_readdata),
        .pix_data       (pix_data),
        .pix_valid      (pix_valid),
        .pix_ready      (pix_ready),
        .pix_sop        (pix_sop),
        .pix_eop        (pix_eop)
    );

    always #5 clk = ~clk;

    // Frame memory: one-cycle read latency, output taken straight from the read register.
    logic [31:0] mem [0:65535];
    logic [31:0] rd_q = '0;
    always @(posedge clk) if (mem_chipselect) rd_q <= mem[mem_address];
    assign mem_readdata = rd_q;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   errors = 0;
    int   checks = 0;
    exp_t exp_q[$];
    int   done_cnt = 0, done_cyc = 0, reads = 0, max_out = 0;
    int   rmode = 0, phase = 0;
    int   start_cyc = 0, done_before = 0, reads_before = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp_v);
        end
    endtask

    // Ready driver: 0 high, 1 pattern 1,0,0,..., 2 low, 3 random.
    always @(posedge clk) begin
        #1;
        case (rmode)
            0: pix_ready = 1'b1;
            1: begin pix_ready = (phase % 3 == 0); phase++; end
            2: pix_ready = 1'b0;
            default: pix_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Monitor: pixel scoreboard, stall stability, read address order, outstanding words.
    int          rd_idx = 0, f_reads = 0, f_pops = 0, f_hs = 0;
    logic        prev_stall = 1'b0;
    logic [17:0] prev_pix = '0;
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            prev_stall = 1'b0;
            rd_idx = 0; f_reads = 0; f_pops = 0; f_hs = 0;
        end else begin
            if (!busy) begin rd_idx = 0; f_reads = 0; f_pops = 0; f_hs = 0; end
            if (done) begin done_cnt++; done_cyc = cyc; end
            if (mem_chipselect) begin
                chk("rd_addr", 64'(mem_address), 64'(BASE + rd_idx));
                rd_idx++; reads++; f_reads++;
            end
            if (f_reads - f_pops > max_out) max_out = f_reads - f_pops;
            if (prev_stall)
                chk("stall_hold", {pix_valid, pix_data, pix_sop, pix_eop}, {1'b1, prev_pix});
            if (pix_valid && pix_ready) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_pixel: got 0x%0h, required no pixel", pix_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("pixel", {pix_data, pix_sop, pix_eop}, {e.d, e.sop, e.eop});
                end
                if (f_hs % 2 == 1) f_pops++;
                f_hs++;
            end
            prev_stall = pix_valid && !pix_ready;
            prev_pix   = {pix_data, pix_sop, pix_eop};
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic fill(input bit ramp);
        mem[BASE - 1]  = $urandom;
        mem[BASE + FW] = $urandom;
        for (int k = 0; k < FW; k++)
            mem[BASE + k] = ramp ? {16'(2 * k + 1), 16'(2 * k)} : $urandom;
    endtask

    task automatic start_frame(input bit tp);
        logic [31:0] w;
        for (int k = 0; k < FW; k++) begin
            w = tp ? {16'(2 * k + 1), 16'(2 * k)} : mem[BASE + k];
            exp_q.push_back('{w[15:0], k == 0, 1'b0});
            exp_q.push_back('{w[31:16], 1'b0, k == FW - 1});
        end
        done_before  = done_cnt;
        reads_before = reads;
        max_out      = 0;
`ifdef PIXEL_FETCH_TEST_PATTERN_EN
        test_pattern = tp;
`endif
        start = 1'b1;
        step();
        start = 1'b0;
        start_cyc = cyc;
    endtask

    task automatic finish_frame(input string tag);
        int n = 0;
        while (done_cnt == done_before && n < 300) begin step(); n++; end
        repeat (3) step();
        chk({tag, "_done_count"}, 64'(done_cnt - done_before), 64'd1);
        chk({tag, "_pixels_left"}, 64'(exp_q.size()), 64'd0);
        chk({tag, "_reads"}, 64'(reads - reads_before), 64'(FW));
        chk({tag, "_busy_after"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int n;
        repeat (3) step();
        chk("reset_outputs",
            {busy, done, mem_chipselect, mem_address, mem_write, mem_byteenable, mem_clken,
             pix_valid, pix_data, pix_sop, pix_eop},
            {3'b000, 16'h0000, 1'b0, 4'hF, 1'b1, 1'b0, 16'h0000, 2'b00});
        reset = 1'b0;
        step();

        // Ramp frame with ready high: latency and throughput.
        rmode = 0;
        fill(1'b1);
        step();
        start_frame(1'b0);
        chk("busy_after_start", 64'(busy), 64'd1);
        n = 0;
        while (!pix_valid && n < 20) begin step(); n++; end
        chk("first_valid_latency", 64'(cyc - start_cyc), 64'd2);
        finish_frame("ramp");
        chk("done_latency", 64'(done_cyc - start_cyc), 64'(2 + 2 * FW));

        // Ready 1,0,0 pattern.
        rmode = 1; phase = 0;
        step();
        start_frame(1'b0);
        finish_frame("toggle");
        chk("max_outstanding", 64'(max_out <= DEPTH), 64'd1);
        chk("max_outstanding_reached", 64'(max_out), 64'(DEPTH));

        // Ready low: exactly DEPTH reads, then chipselect holds low.
        fill(1'b0);
        rmode = 2;
        step(); step();
        start_frame(1'b0);
        repeat (20) step();
        chk("reads_while_stalled", 64'(reads - reads_before), 64'(DEPTH));
        chk("cs_low_while_full", 64'(mem_chipselect), 64'd0);
        rmode = 0;
        finish_frame("stall");

        // Reset in the middle of fetch, then a clean frame.
        step();
        start_frame(1'b0);
        n = 0;
        while (reads - reads_before < 2 && n < 20) begin step(); n++; end
        reset = 1'b1;
        step();
        chk("midreset_outputs",
            {busy, done, mem_chipselect, mem_address, pix_valid, pix_data, pix_sop, pix_eop},
            {3'b000, 16'h0000, 1'b0, 16'h0000, 2'b00});
        reset = 1'b0;
        exp_q.delete();
        step(); step();
        start_frame(1'b0);
        finish_frame("post_reset");

        // Start pulses while busy, including the done edge.
        step();
        start_frame(1'b0);
        repeat (3) step();
        start = 1'b1; step(); start = 1'b0;
        while (cyc < start_cyc + 2 * FW + 1) step();
        start = 1'b1; step(); start = 1'b0;
        finish_frame("start_in_busy");

        // Randomized contents and ready behaviour.
        for (int i = 0; i < 8; i++) begin
            fill(1'b0);
            rmode = (i % 3 == 0) ? 0 : ((i % 3 == 1) ? 1 : 3);
            step();
            start_frame(1'b0);
            finish_frame("random");
        end

`ifdef PIXEL_FETCH_TEST_PATTERN_EN
        fill(1'b0);
        rmode = 0;
        step();
        start_frame(1'b1);
        finish_frame("test_pattern");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

endmodule
